// File: rtl/nes_clk_pkg.sv
// nes_clk_pkg: shared state encoding and master-clock divider ratios for the NES clock sequencer.
// Define PAL_TIMING_EN for 2A07/2C07 ratios; the default build uses NTSC ratios.
package nes_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN,
        SOFT_RST
    } state_e;

`ifdef PAL_TIMING_EN
    localparam int CPU_DIV = 16;
    localparam int PPU_DIV = 5;
    localparam int M2_RISE = 6;
`else
    localparam int CPU_DIV = 12;
    localparam int PPU_DIV = 4;
    localparam int M2_RISE = 5;
`endif

    localparam int CPU_W = $clog2(CPU_DIV);
    localparam int PPU_W = $clog2(PPU_DIV);

endpackage

// File: rtl/nes_ce_divider.sv
// nes_ce_divider: wrapping modulo-DIV counter producing a registered one-cycle pulse on each arrival at 0.
// clear loads 0 (pulsing unless also held); hold freezes the count and suppresses the pulse.
module nes_ce_divider #(
    parameter int DIV = 4,
    parameter int W   = $clog2(DIV)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         hold,
    output logic [W-1:0] cnt,
    output logic         ce
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ce_q, ce_d;

    always_comb begin
        cnt_d = clear ? '0 : hold ? cnt_q : (cnt_q == W'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        ce_d  = !hold && cnt_d == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign cnt = cnt_q;
    assign ce  = ce_q;

endmodule

// File: rtl/nes_clock_sequencer.sv
// nes_clock_sequencer: PLL-lock gated reset sequencing plus CPU/PPU clock-enables and M2 for the NES core.
// Divider ratios come from nes_clk_pkg (PAL_TIMING_EN selects PAL timing).
module nes_clock_sequencer
    import nes_clk_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 1024,
    parameter int SOFT_RST_CYCLES = 120,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic soft_rst_req,
    input  logic pause,
    input  logic clr_status,
    output logic sys_rst_n,
    output logic cpu_ce,
    output logic ppu_ce,
    output logic m2,
    output logic running,
    output logic lock_lost
);

    localparam int MAX_CYCLES = SETTLE_CYCLES > SOFT_RST_CYCLES ? SETTLE_CYCLES : SOFT_RST_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sys_rst_n_q, running_q, lock_lost_q, lock_lost_d;
    logic                   lock_s, active_d;
    logic [CPU_W-1:0]       cpu_div;
    logic [PPU_W-1:0]       ppu_div;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // One counter serves both the settle delay and the soft-reset hold.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], pll_locked};
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        lock_lost_d = lock_lost_q & ~clr_status;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = SETTLE;
            end
            SETTLE: begin
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d     = WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end else if (soft_rst_req) state_d = SOFT_RST;
            end
            SOFT_RST: begin
                if (!lock_s) begin
                    state_d     = WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end else if (soft_rst_req) cnt_d = '0;
                else if (cnt_q == CW'(SOFT_RST_CYCLES - 1)) state_d = RUN;
            end
            default: state_d = WAIT_LOCK;
        endcase
        active_d = state_d == RUN || state_d == SOFT_RST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            sync_q      <= '0;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= state_d == RUN;
            running_q   <= active_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Entering an active state restarts both phases at 0 with a pulse; inactive states park them silently.
    nes_ce_divider #(.DIV(CPU_DIV), .W(CPU_W)) u_cpu_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!active_d || !running_q),
        .hold  (!active_d || (running_q && pause)),
        .cnt   (cpu_div),
        .ce    (cpu_ce)
    );

    nes_ce_divider #(.DIV(PPU_DIV), .W(PPU_W)) u_ppu_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!active_d || !running_q),
        .hold  (!active_d || (running_q && pause)),
        .cnt   (ppu_div),
        .ce    (ppu_ce)
    );

    always_ff @(posedge clk)
        if (running_q) assert (int'(cpu_div) < CPU_DIV && int'(ppu_div) < PPU_DIV);

    assign m2        = cpu_div >= CPU_W'(M2_RISE);
    assign sys_rst_n = sys_rst_n_q;
    assign running   = running_q;
    assign lock_lost = lock_lost_q;

endmodule
